// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared definitions for the AHB round-robin arbiter.
//   ahb_idx_w(n)    : index width for n items, never less than 1 bit
//   htrans_e        : AHB HTRANS encoding
//   HOLD_UNLIMITED  : MAX_HOLD value that disables the hold limit
package ahb_arb_pkg;

   localparam int unsigned HOLD_UNLIMITED = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   function automatic int unsigned ahb_idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req     : request vector, N bits
//   start   : index holding the highest priority this cycle
//   winner  : first set req bit found from start upward, wrapping mod N
//   any_req : at least one req bit is set
module rr_pick
   import ahb_arb_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = ahb_idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] winner,
   output logic         any_req
);

   int unsigned idx;
   logic [W-1:0] sel;

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = (32'(start) + 32'(k)) % N;
         sel = W'(idx);
         if (req[sel]) begin
            winner  = sel;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: parametrised AHB round-robin bus arbiter with hold limit
// and parking on DEFAULT_MASTER.
//   HCLK, HRESETn : clock (rising edge), asynchronous active-low reset
//   hbusreq       : per-master bus request
//   hready        : shared HREADY; all state advances only when 1
//   hlock         : per-master lock (only when AHB_ARB_HLOCK_EN is defined)
//   hgrant        : registered one-hot grant
//   hmaster       : registered address-phase owner index
//   hmaster_d     : hmaster delayed one hready cycle (data-phase mux select)
//   hmastlock     : registered locked-transfer indicator (0 without the macro)
// Optional feature macro: AHB_ARB_HLOCK_EN.
module ahb_rr_arbiter
   import ahb_arb_pkg::*;
#(
   parameter  int unsigned NUM_MASTERS    = 8,
   parameter  int unsigned MAX_HOLD       = 16,
   parameter  int unsigned DEFAULT_MASTER = 0,
   localparam int unsigned MW             = ahb_idx_w(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic                   hready,
`ifdef AHB_ARB_HLOCK_EN
   input  logic [NUM_MASTERS-1:0] hlock,
`endif
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MW-1:0]          hmaster,
   output logic [MW-1:0]          hmaster_d,
   output logic                   hmastlock
);

   localparam int unsigned HW        = ahb_idx_w(MAX_HOLD);
   localparam int unsigned HOLD_LAST = (MAX_HOLD == HOLD_UNLIMITED) ? 0 : MAX_HOLD - 1;
   localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);
   localparam logic [MW-1:0] LAST_IDX = MW'(NUM_MASTERS - 1);
   localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

   if (DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
      $error("ahb_rr_arbiter: DEFAULT_MASTER %0d out of range", DEFAULT_MASTER);
   end
   if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_count
      $error("ahb_rr_arbiter: NUM_MASTERS %0d outside 2..16", NUM_MASTERS);
   end

   logic [MW-1:0]          own_q, own_d;
   logic [MW-1:0]          dph_q, dph_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
   logic [MW-1:0]          start_idx, winner;
   logic                   any_req, hold_ok, locked;

   // Search begins just past the current owner, so the owner is last in line.
   assign start_idx = (own_q == LAST_IDX) ? '0 : own_q + MW'(1);
   assign hold_ok   = (MAX_HOLD == HOLD_UNLIMITED) || (hold_cnt_q < HW'(HOLD_LAST));

`ifdef AHB_ARB_HLOCK_EN
   logic lock_q, lock_d;
   assign locked = hlock[own_q];
`else
   assign locked = 1'b0;
`endif

   rr_pick #(
      .N (NUM_MASTERS),
      .W (MW)
   ) u_pick (
      .req     (hbusreq),
      .start   (start_idx),
      .winner  (winner),
      .any_req (any_req)
   );

   // Next-state: keep, rotate, or park; everything frozen while hready=0.
   always_comb begin
      own_d      = own_q;
      dph_d      = dph_q;
      grant_d    = grant_q;
      hold_cnt_d = hold_cnt_q;
`ifdef AHB_ARB_HLOCK_EN
      lock_d     = lock_q;
`endif
      if (hready) begin
         dph_d = own_q;
         if (locked) begin
            hold_cnt_d = '0;
         end else if (hbusreq[own_q] && hold_ok) begin
            if (MAX_HOLD != HOLD_UNLIMITED) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end else begin
            own_d      = any_req ? winner : DEF_IDX;
            hold_cnt_d = '0;
         end
         grant_d = NUM_MASTERS'(1) << own_d;
`ifdef AHB_ARB_HLOCK_EN
         lock_d  = locked;
`endif
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         own_q      <= DEF_IDX;
         dph_q      <= DEF_IDX;
         grant_q    <= GRANT_RST;
         hold_cnt_q <= '0;
`ifdef AHB_ARB_HLOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         own_q      <= own_d;
         dph_q      <= dph_d;
         grant_q    <= grant_d;
         hold_cnt_q <= hold_cnt_d;
`ifdef AHB_ARB_HLOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

   assign hgrant    = grant_q;
   assign hmaster   = own_q;
   assign hmaster_d = dph_q;
`ifdef AHB_ARB_HLOCK_EN
   assign hmastlock = lock_q;
`else
   assign hmastlock = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed and randomized stimulus for ahb_rr_arbiter
// (4 masters, hold limit 4, park on master 0) checked against a
// behavioural model of the arbitration rules.
module tb_ahb_rr_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned M   = 4;
   localparam int unsigned DEF = 0;
   localparam int unsigned MW  = 2;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [N-1:0]  hbusreq;
   logic          hready;
   logic [N-1:0]  hgrant;
   logic [MW-1:0] hmaster;
   logic [MW-1:0] hmaster_d;
   logic          hmastlock;
`ifdef AHB_ARB_HLOCK_EN
   logic [N-1:0]  hlock;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model state: current owner, data-phase owner, cycles held so far, lock.
   int m_own;
   int m_dph;
   int m_held;
   bit m_lock;

   always #5 HCLK = ~HCLK;

   ahb_rr_arbiter #(
      .NUM_MASTERS    (N),
      .MAX_HOLD       (M),
      .DEFAULT_MASTER (DEF)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .hbusreq   (hbusreq),
      .hready    (hready),
`ifdef AHB_ARB_HLOCK_EN
      .hlock     (hlock),
`endif
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmaster_d (hmaster_d),
      .hmastlock (hmastlock)
   );

   task automatic mdl_reset();
      m_own  = DEF;
      m_dph  = DEF;
      m_held = 1;
      m_lock = 1'b0;
   endtask

   // One rising edge of the arbitration rules.
   task automatic mdl_edge();
      bit lk;
      bit found;
      int nxt;
      logic [N-1:0] r;
      if (!HRESETn) begin
         mdl_reset();
         return;
      end
      if (!hready) return;
      r  = hbusreq;
      lk = 1'b0;
`ifdef AHB_ARB_HLOCK_EN
      lk = hlock[m_own];
`endif
      m_dph = m_own;
      if (lk) begin
         m_held = 1;
      end else if (r[m_own] && m_held < int'(M)) begin
         m_held = m_held + 1;
      end else begin
         found = 1'b0;
         nxt   = DEF;
         for (int i = 1; i <= int'(N); i++) begin
            if (!found && r[(m_own + i) % N]) begin
               nxt   = (m_own + i) % N;
               found = 1'b1;
            end
         end
         m_own  = nxt;
         m_held = 1;
      end
      m_lock = lk;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] g;
      g = '0;
      g[m_own] = 1'b1;
      chk({tag, ".hmaster"},   32'(hmaster),   32'(m_own));
      chk({tag, ".hgrant"},    32'(hgrant),    32'(g));
      chk({tag, ".hmaster_d"}, 32'(hmaster_d), 32'(m_dph));
      chk({tag, ".hmastlock"}, 32'(hmastlock), 32'(m_lock));
   endtask

   task automatic step(input logic [N-1:0] req, input logic rdy, input string tag);
      hbusreq = req;
      hready  = rdy;
      @(posedge HCLK);
      mdl_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      HRESETn = 1'b0;
      hbusreq = '0;
      hready  = 1'b1;
`ifdef AHB_ARB_HLOCK_EN
      hlock   = '0;
`endif
      mdl_reset();
      #12;
      check_all("reset");
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Reset mid-grant with owner 2, requests ignored while in reset.
      step(4'b0100, 1'b1, "grab2");
      chk("grab2_const", 32'(hmaster), 32'd2);
      step(4'b0100, 1'b1, "grab2_hold");
      #2;
      HRESETn = 1'b0;
      #1;
      mdl_reset();
      check_all("async_rst");
      chk("async_rst_grant", 32'(hgrant), 32'h1);
      step(4'b0100, 1'b1, "in_rst");
      step(4'b0100, 1'b1, "in_rst");
      HRESETn = 1'b1;
      repeat (3) step(4'b0000, 1'b1, "park");

      // Rotation through 2, 3, 0 with master 1 silent.
      step(4'b0010, 1'b1, "to1");
      repeat (16) step(4'b1101, 1'b1, "rotate");

      // Lone requester keeps being re-granted.
      repeat (12) step(4'b0100, 1'b1, "lone");
      chk("lone_const", 32'(hmaster), 32'd2);

      // hready stall with owner 3 part way through its hold.
      repeat (3) step(4'b1000, 1'b1, "own3");
      repeat (5) step(4'b1001, 1'b0, "stall");
      chk("stall_const", 32'(hmaster), 32'd3);
      step(4'b1001, 1'b1, "unstall");
      chk("unstall_keep", 32'(hmaster), 32'd3);
      step(4'b1001, 1'b1, "unstall");
      chk("stall_move", 32'(hmaster), 32'd0);

      // Owner drops its request.
      step(4'b0001, 1'b1, "own0");
      step(4'b1010, 1'b1, "drop0");
      chk("drop0_const", 32'(hmaster), 32'd1);
      step(4'b1000, 1'b1, "drop1");
      chk("drop1_const", 32'(hmaster), 32'd3);

`ifdef AHB_ARB_HLOCK_EN
      // Locked owner keeps the bus past its hold limit.
      step(4'b0100, 1'b1, "own2");
      hlock = 4'b0100;
      repeat (10) step(4'b1111, 1'b1, "locked");
      chk("locked_const", 32'(hmaster), 32'd2);
      chk("locked_flag", 32'(hmastlock), 32'd1);
      hlock = 4'b0000;
      step(4'b1011, 1'b1, "unlock");
      chk("unlock_const", 32'(hmaster), 32'd3);
`endif

      // Randomized requests and hready stalls.
      for (int i = 0; i < 400; i++) begin
`ifdef AHB_ARB_HLOCK_EN
         hlock = ($urandom_range(7) == 0) ? N'($urandom) : '0;
`endif
         step(N'($urandom), ($urandom_range(3) != 0), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
